// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address view, frame layout and FSM states.
package cpu_types_pkg;

   localparam int unsigned ICACHE_SETS = 16;
   localparam int unsigned ICACHE_IDX  = $clog2(ICACHE_SETS);
   localparam int unsigned ICACHE_TAGW = 30 - ICACHE_IDX;

   typedef struct packed {
      logic [ICACHE_TAGW-1:0] tag;
      logic [ICACHE_IDX-1:0]  idx;
      logic [1:0]             bytoff;
   } icachef_t;

   typedef struct packed {
      logic                   valid;
      logic [ICACHE_TAGW-1:0] tag;
      logic [31:0]            data;
   } icache_frame_t;

   typedef enum logic {
      IDLE,
      FETCH
   } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame store: synchronous write, combinational read, valid bits cleared on reset.
module icache_array
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = 16,
   parameter int unsigned IDX  = $clog2(SETS),
   parameter int unsigned TAGW = 30 - IDX
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            we_i,
   input  logic [IDX-1:0]  widx_i,
   input  logic [TAGW-1:0] wtag_i,
   input  logic [31:0]     wdata_i,
   input  logic [IDX-1:0]  ridx_i,
   output logic            rvalid_o,
   output logic [TAGW-1:0] rtag_o,
   output logic [31:0]     rdata_o
);

   logic [SETS-1:0] valid_q;
   logic [TAGW-1:0] tag_q  [SETS];
   logic [31:0]     data_q [SETS];

   // Reset wins over a same-edge fill, so an interrupted fill never becomes valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[widx_i] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (we_i) begin
         tag_q[widx_i]  <= wtag_i;
         data_q[widx_i] <= wdata_i;
      end
   end

   assign rvalid_o = valid_q[ridx_i];
   assign rtag_o   = tag_q[ridx_i];
   assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: hit/miss FSM, single-word fill with bypass, perf counters.
module icache
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int unsigned IDX  = $clog2(SETS);
   localparam int unsigned TAGW = 30 - IDX;

   icache_state_t state_q, state_d;
   logic [31:0]   miss_addr_q, miss_addr_d;
   logic [31:0]   hit_cnt_q, miss_cnt_q;
   logic          hit_inc, miss_inc, fill_we;

   logic [TAGW-1:0] tag;
   logic [IDX-1:0]  idx;
   logic            rvalid;
   logic [TAGW-1:0] rtag;
   logic [31:0]     rdata;

   assign tag = imemaddr[31:IDX+2];
   assign idx = imemaddr[IDX+1:2];

   icache_array #(
      .SETS (SETS),
      .IDX  (IDX),
      .TAGW (TAGW)
   ) u_array (
      .CLK      (CLK),
      .RST      (RST),
      .we_i     (fill_we),
      .widx_i   (miss_addr_q[IDX+1:2]),
      .wtag_i   (miss_addr_q[31:IDX+2]),
      .wdata_i  (iload),
      .ridx_i   (idx),
      .rvalid_o (rvalid),
      .rtag_o   (rtag),
      .rdata_o  (rdata)
   );

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      ihit        = 1'b0;
      imemload    = '0;
      iREN        = 1'b0;
      iaddr       = '0;
      fill_we     = 1'b0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (imemREN) begin
               if (rvalid && (rtag == tag)) begin
                  ihit     = 1'b1;
                  imemload = rdata;
                  hit_inc  = 1'b1;
               end else begin
                  // Byte offset is forced to zero; the AND keeps the ignored bits referenced.
                  miss_addr_d = {imemaddr[31:2], imemaddr[1:0] & 2'b00};
                  miss_inc    = 1'b1;
                  state_d     = FETCH;
               end
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = miss_addr_q;
            if (!iwait) begin
               fill_we = 1'b1;
               state_d = IDLE;
               if (imemREN && (imemaddr[31:2] == miss_addr_q[31:2])) begin
                  ihit     = 1'b1;
                  imemload = iload;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         if (hit_inc && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_inc && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict eviction, redirect mid-fill, reset in FETCH, offset alias.
module tb_icache;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   icache #(.SETS(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic ren, input logic [31:0] addr, input logic w, input logic [31:0] ld);
      imemREN  = ren;
      imemaddr = addr;
      iwait    = w;
      iload    = ld;
      #2;
   endtask

   initial begin
      RST = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 32'h0);
      step();
      RST = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 32'h0);
      chk("rst_ihit", {31'b0, ihit}, 32'h0);
      chk("rst_load", imemload, 32'h0);
      chk("rst_iren", {31'b0, iREN}, 32'h0);
      chk("rst_iaddr", iaddr, 32'h0);
      chk("rst_hcnt", hit_count, 32'h0);
      chk("rst_mcnt", miss_count, 32'h0);

      // Cold miss on 0x0, two wait cycles then data.
      drive(1'b1, 32'h0, 1'b1, 32'h0);
      chk("cold_idle_ihit", {31'b0, ihit}, 32'h0);
      chk("cold_idle_iren", {31'b0, iREN}, 32'h0);
      step();
      drive(1'b1, 32'h0, 1'b1, 32'h0);
      chk("cold_f1_iren", {31'b0, iREN}, 32'h1);
      chk("cold_f1_iaddr", iaddr, 32'h0);
      chk("cold_f1_ihit", {31'b0, ihit}, 32'h0);
      chk("cold_mcnt", miss_count, 32'h1);
      step();
      drive(1'b1, 32'h0, 1'b1, 32'h0);
      chk("cold_f2_iren", {31'b0, iREN}, 32'h1);
      chk("cold_f2_ihit", {31'b0, ihit}, 32'h0);
      step();
      drive(1'b1, 32'h0, 1'b0, 32'h2001_0005);
      chk("cold_f3_iren", {31'b0, iREN}, 32'h1);
      chk("cold_f3_ihit", {31'b0, ihit}, 32'h1);
      chk("cold_f3_load", imemload, 32'h2001_0005);
      step();

      // Refetch hits same cycle.
      drive(1'b1, 32'h0, 1'b1, 32'h0);
      chk("hit_ihit", {31'b0, ihit}, 32'h1);
      chk("hit_load", imemload, 32'h2001_0005);
      chk("hit_iren", {31'b0, iREN}, 32'h0);
      chk("hit_mcnt", miss_count, 32'h1);
      step();
      chk("hit_hcnt", hit_count, 32'h1);

      // Conflict: 0x40 maps to idx 0 with tag 1.
      drive(1'b1, 32'h40, 1'b1, 32'h0);
      chk("evict_miss", {31'b0, ihit}, 32'h0);
      step();
      drive(1'b1, 32'h40, 1'b0, 32'hAAAA_0040);
      chk("evict_iaddr", iaddr, 32'h40);
      chk("evict_byp", imemload, 32'hAAAA_0040);
      step();
      drive(1'b1, 32'h0, 1'b1, 32'h0);
      chk("evict_0_miss", {31'b0, ihit}, 32'h0);
      step();
      chk("evict_mcnt", miss_count, 32'h3);
      drive(1'b1, 32'h0, 1'b0, 32'h2001_0005);
      chk("evict_0_byp", imemload, 32'h2001_0005);
      step();

      // Redirect mid-fill: miss on 0x10, then address moves to 0x20.
      drive(1'b1, 32'h10, 1'b1, 32'h0);
      step();
      drive(1'b1, 32'h20, 1'b1, 32'h0);
      chk("redir_w_ihit", {31'b0, ihit}, 32'h0);
      chk("redir_iaddr", iaddr, 32'h10);
      step();
      drive(1'b1, 32'h20, 1'b0, 32'h1111_0010);
      chk("redir_done_ihit", {31'b0, ihit}, 32'h0);
      chk("redir_done_load", imemload, 32'h0);
      step();
      drive(1'b1, 32'h20, 1'b1, 32'h0);
      chk("redir_20_miss", {31'b0, ihit}, 32'h0);
      chk("redir_20_iren", {31'b0, iREN}, 32'h0);
      step();
      drive(1'b1, 32'h20, 1'b0, 32'h2222_0020);
      chk("redir_20_iaddr", iaddr, 32'h20);
      chk("redir_20_byp", imemload, 32'h2222_0020);
      step();
      drive(1'b1, 32'h10, 1'b1, 32'h0);
      chk("redir_10_hit", {31'b0, ihit}, 32'h1);
      chk("redir_10_load", imemload, 32'h1111_0010);
      step();
      drive(1'b1, 32'h13, 1'b1, 32'h0);
      chk("alias_hit", {31'b0, ihit}, 32'h1);
      chk("alias_load", imemload, 32'h1111_0010);
      step();
      chk("pre_rst_hcnt", hit_count, 32'h3);
      chk("pre_rst_mcnt", miss_count, 32'h5);

      // Reset while in FETCH; the completing fill must be dropped.
      drive(1'b1, 32'h80, 1'b1, 32'h0);
      step();
      RST = 1'b1;
      drive(1'b1, 32'h80, 1'b0, 32'hDEAD_0080);
      chk("rstf_iren_before", {31'b0, iREN}, 32'h1);
      step();
      RST = 1'b0;
      drive(1'b0, 32'h80, 1'b1, 32'h0);
      chk("rstf_iren", {31'b0, iREN}, 32'h0);
      chk("rstf_iaddr", iaddr, 32'h0);
      chk("rstf_hcnt", hit_count, 32'h0);
      chk("rstf_mcnt", miss_count, 32'h0);
      drive(1'b1, 32'h80, 1'b1, 32'h0);
      chk("rstf_80_miss", {31'b0, ihit}, 32'h0);
      step();
      drive(1'b1, 32'h80, 1'b0, 32'h8888_0080);
      chk("rstf_80_byp", imemload, 32'h8888_0080);
      step();
      drive(1'b1, 32'h0, 1'b1, 32'h0);
      chk("rstf_0_miss", {31'b0, ihit}, 32'h0);
      step();
      chk("rstf_mcnt2", miss_count, 32'h2);
      chk("rstf_hcnt2", hit_count, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b1, 32'h0);
      chk("final_iren", {31'b0, iREN}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the datapath's instruction-fetch port and the memory controller's instruction port.
- Hit: returns the instruction word combinationally.
- Miss: runs a single-word fill from memory, with the returned word bypassed straight to the datapath.
- Keeps hit and miss counters for performance reporting.

## Interface
Parameters:
- SETS, 16, number of frames; power of two, ≥2. IDX = log2(SETS), TAGW = 30 − IDX.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  reset: one clock, synchronous, active-high
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  instruction valid this cycle
- imemload  out  32  instruction word; 32'h0 whenever ihit=0
- iREN  out  1  memory read request
- iaddr  out  32  memory word address
- iwait  in  1  memory busy; iload valid when iwait=0 and iREN=1
- iload  in  32  memory read data
- hit_count  out  32  saturating count of hit-path ihit pulses
- miss_count  out  32  saturating count of fills started

## Operation
- Address split:
  - tag = imemaddr[31:IDX+2]
  - idx = imemaddr[IDX+1:2]
  - byte offset [1:0] ignored
- Frame: {valid, tag[TAGW], data[32]}.
- FSM states: IDLE, FETCH.
- IDLE behaviour:
  - ihit = imemREN & frame[idx].valid & (frame[idx].tag == tag).
  - On hit: imemload = frame[idx].data; hit_count increments at the edge.
  - On miss with imemREN=1: latch miss_addr = {imemaddr[31:2],2'b00}, increment miss_count, go to FETCH.
  - iREN=0, iaddr=32'h0.
- FETCH behaviour:
  - iREN=1, iaddr=miss_addr.
  - While iwait=1: stay in FETCH; ihit=0.
  - When iwait=0:
    - Write frame[miss_idx] = {1, miss_tag, iload}.
    - Go to IDLE.
    - ihit = imemREN & (imemaddr[31:2] == miss_addr[31:2]); when asserted, imemload = iload (bypass).
  - A bypassed ihit does not increment hit_count.
- Fetch-request boundaries:
  - imemREN drops, or imemaddr changes (redirect), mid-FETCH: the fill still completes and the frame is written. ihit follows the FETCH rule, so it stays 0 for a mismatched address.
  - The new address is looked up in IDLE on the following cycle.
- Counters saturate at 32'hFFFF_FFFF.
- No writes from the datapath; no flush port. Self-modifying code is unsupported.

## Timing
- Reset (RST=1 at an edge), applied in any state:
  - state←IDLE
  - all valid←0
  - miss_addr←0
  - hit_count, miss_count←0
- Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- Mid-FETCH reset drops iREN the cycle after the edge. The in-flight fill is discarded and not written.
- Hit latency: 0 cycles, combinational from imemaddr.
- Miss latency:
  - Cycle 0: miss detected in IDLE.
  - Cycle 1: first FETCH cycle with iREN=1.
  - ihit rises in the first FETCH cycle where iwait=0.
  - Minimum miss penalty is 1 extra cycle. With memory latency L cycles of iwait=1, ihit arrives at cycle 1+L.
- Frame write and return to IDLE occur at the same edge that ends the iwait=0 FETCH cycle. A repeat fetch of that address then hits in the next cycle.
- iREN/iaddr are Moore outputs (state and miss_addr only). They must not combinationally depend on imemaddr.

## Structure
- cpu_types_pkg additions:
  - icachef_t: packed {tag, idx, bytoff} address view, sized for SETS=16.
  - icache_frame_t: packed {valid, tag, data}.
  - icache_state_t enum {IDLE, FETCH}.
- Natural sub-module: icache_array.
  - Holds SETS frames with synchronous write and combinational read.
  - Clears valid bits on RST.
- icache itself contains the FSM, miss latch, bypass mux and counters.

## Test plan
- Reset then cold fetch of 0x0000_0000 with memory returning 0x2001_0005 after 2 iwait cycles:
  - iREN high for 3 cycles with iaddr=0x0.
  - ihit on the 3rd FETCH cycle with imemload=0x2001_0005.
  - miss_count=1.
- Refetch of 0x0000_0000 next cycle: ihit same cycle, no iREN, hit_count=1.
- Conflict eviction (SETS=16): fetch 0x0000_0040, which maps to idx 0 with a different tag.
  - Result: miss, refill.
  - A subsequent fetch of 0x0 misses again; miss_count=3.
- Redirect mid-fill: miss on 0x0000_0010, then imemaddr changes to 0x0000_0020 while iwait=1.
  - ihit stays 0 during the fill, and frame 4 is filled.
  - Next cycle 0x20 misses; a later fetch of 0x10 hits.
- RST asserted in FETCH:
  - iREN=0 the next cycle.
  - Previously valid address 0x0 misses after reset.
  - Counters read 0.
- Byte-offset alias: fetch 0x0000_0013 after filling 0x0000_0010 → hit with the same data.
